// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor.
//   - Default parameter values (XLEN, ENTRIES, CNT_W).
//   - Index/tag width functions derived from the PC width and table size.
//   - Saturating-counter encodings (weakly taken / weakly not taken).
package bp_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ENTRIES_DEF = 16;
  localparam int CNT_W_DEF   = 2;
  localparam int CNT_W_MAX   = 4;

  // PC bits [1:0] are always dropped, so the index sits at [IW+1:2].
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Weakly taken: MSB set, remaining bits clear.
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_taken(input int w);
    return CNT_W_MAX'(1) << (w - 1);
  endfunction

  // Weakly not taken: MSB clear, remaining bits set (one below weakly taken).
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_not_taken(input int w);
    return cnt_weak_taken(w) - CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state logic (purely combinational).
// Ports:
//   cnt       - current counter value
//   inc       - 1: count up (taken), 0: count down (not taken)
//   force_max - jump to all-ones regardless of inc (unconditional jumps)
//   nxt       - next counter value, saturating at all-ones and zero
module sat_counter #(
  parameter int CNT_W = bp_pkg::CNT_W_DEF
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             force_max,
  output logic [CNT_W-1:0] nxt
);

  localparam logic [CNT_W-1:0] MAX = '1;

  always_comb begin
    nxt = cnt;
    if (force_max)       nxt = MAX;
    else if (inc) begin
      if (cnt != MAX)    nxt = cnt + CNT_W'(1);
    end else if (cnt != '0) nxt = cnt - CNT_W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + bimodal BHT branch predictor.
// Lookup is combinational on pc_f against current table state (no bypass of
// a same-cycle update). Updates are written on the rising clock edge.
// Ports:
//   clk, rstn                 - clock, async active-low reset
//   pc_f                      - fetch PC to predict
//   pred_hit/taken/target     - lookup result (target = pc_f+4 unless taken)
//   upd_*                     - resolved control-flow instruction
//   stat_upd, stat_miss       - update / mispredict counters
// Optional feature: define BP_STATS_EN to build the saturating statistic
// counters; otherwise both stat outputs are tied to zero.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_is_jmp,
  input  logic            upd_mispred,
  output logic [31:0]     stat_upd,
  output logic [31:0]     stat_miss
);

  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(XLEN, ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

  logic [ENTRIES-1:0]                 valid;
  logic [ENTRIES-1:0][TW-1:0]         tag;
  logic [ENTRIES-1:0][XLEN-1:0]       tgt;
  logic [ENTRIES-1:0][CNT_W-1:0]      cnt;

  // ---------------- lookup ----------------
  logic [IW-1:0] f_idx;
  logic [TW-1:0] f_tag;

  assign f_idx       = pc_f[IW+1:2];
  assign f_tag       = pc_f[XLEN-1:IW+2];
  assign pred_hit    = valid[f_idx] && (tag[f_idx] == f_tag);
  assign pred_taken  = pred_hit && cnt[f_idx][CNT_W-1];
  assign pred_target = pred_taken ? tgt[f_idx] : pc_f + XLEN'(4);

  // ---------------- update ----------------
  logic [IW-1:0]    u_idx;
  logic [TW-1:0]    u_tag;
  logic             u_hit;
  logic             u_force;
  logic [CNT_W-1:0] cnt_nxt;

  assign u_idx   = upd_pc[IW+1:2];
  assign u_tag   = upd_pc[XLEN-1:IW+2];
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign u_force = upd_is_jmp && upd_taken;

  sat_counter #(.CNT_W(CNT_W)) u_sat (
    .cnt       (cnt[u_idx]),
    .inc       (upd_taken),
    .force_max (u_force),
    .nxt       (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      tag   <= '0;
      tgt   <= '0;
      cnt   <= {ENTRIES{CNT_WNT}};
    end else if (upd_valid) begin
      if (u_hit) begin
        cnt[u_idx] <= cnt_nxt;
        if (upd_taken) tgt[u_idx] <= upd_target;
      end else if (upd_taken) begin
        // Allocate, overwriting whatever aliased entry lived at this index.
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
        tgt[u_idx]   <= upd_target;
        cnt[u_idx]   <= u_force ? '1 : CNT_WT;
      end
    end
  end

  // Low PC bits never participate in indexing.
  logic pc_lsb_unused;
  assign pc_lsb_unused = ^{pc_f[1:0], upd_pc[1:0]};

  // ---------------- statistics ----------------
`ifdef BP_STATS_EN
  logic [31:0] upd_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd_valid && upd_cnt != '1)                  upd_cnt  <= upd_cnt + 32'd1;
      if (upd_valid && upd_mispred && miss_cnt != '1)  miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign stat_upd  = upd_cnt;
  assign stat_miss = miss_cnt;
`else
  logic stats_unused;
  assign stats_unused = upd_mispred;
  assign stat_upd     = '0;
  assign stat_miss    = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor (XLEN=32, ENTRIES=16, CNT_W=2).
// Each vector is driven after a falling edge and checked 1ns later, i.e. the
// lookup sees pre-update state; the following rising edge applies the update.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] pc_f = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_is_jmp = 1'b0;
  logic        upd_mispred = 1'b0;
  logic [31:0] stat_upd, stat_miss;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .pc_f(pc_f),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jmp(upd_is_jmp), .upd_mispred(upd_mispred),
    .stat_upd(stat_upd), .stat_miss(stat_miss)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        um;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic uj,
                              input logic um, input logic eh, input logic et,
                              input logic [31:0] etgt);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uj = uj; v.um = um;
    v.eh = eh; v.et = et; v.etgt = etgt;
    vt.push_back(v);
  endfunction

  task automatic drive_upd(input logic uv, input logic [31:0] upc, input logic ut,
                           input logic [31:0] utgt, input logic uj, input logic um);
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_is_jmp = uj; upd_mispred = um;
  endtask

  task automatic check_pred(input string name, input logic h, input logic t, input logic [31:0] tg);
    check({name, " hit"},    32'(pred_hit),   32'(h));
    check({name, " taken"},  32'(pred_taken), 32'(t));
    check({name, " target"}, pred_target,     tg);
  endtask

  logic [31:0] exp_upd, exp_miss;

  initial begin
    // pc, uv, upc, ut, utgt, uj, um | hit, taken, target
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h104); // 0 empty table
    add(32'h100, 1, 32'h100, 1, 32'h080, 0, 1,  0, 0, 32'h104); // 1 same-cycle alloc: no bypass
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h080); // 2 weakly taken
    add(32'h100, 1, 32'h100, 0, 32'h000, 0, 1,  1, 1, 32'h080); // 3 not-taken update (pre state)
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  1, 0, 32'h104); // 4 counter 01
    add(32'h140, 1, 32'h140, 1, 32'h200, 0, 0,  0, 0, 32'h144); // 5 alias miss, allocate
    add(32'h140, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h200); // 6 new tag hits
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h104); // 7 old tag evicted
    add(32'h010, 1, 32'h010, 1, 32'h300, 1, 0,  0, 0, 32'h014); // 8 jal alloc -> 11
    add(32'h010, 1, 32'h010, 0, 32'h000, 0, 0,  1, 1, 32'h300); // 9 11 -> 10
    add(32'h010, 1, 32'h010, 0, 32'h000, 0, 0,  1, 1, 32'h300); // 10 10 -> 01
    add(32'h010, 1, 32'h010, 0, 32'h000, 0, 0,  1, 0, 32'h014); // 11 01 -> 00
    add(32'h010, 0, 32'h000, 0, 32'h000, 0, 0,  1, 0, 32'h014); // 12 counter 00
    add(32'h010, 1, 32'h010, 0, 32'h000, 0, 0,  1, 0, 32'h014); // 13 saturate at 00
    add(32'h010, 1, 32'h010, 1, 32'h400, 0, 0,  1, 0, 32'h014); // 14 00 -> 01, target 0x400
    add(32'h010, 0, 32'h000, 0, 32'h000, 0, 0,  1, 0, 32'h014); // 15 01 still not taken
    add(32'h010, 1, 32'h010, 1, 32'h400, 0, 0,  1, 0, 32'h014); // 16 01 -> 10
    add(32'h010, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h400); // 17 taken, new target
    add(32'h020, 1, 32'h020, 0, 32'h000, 0, 0,  0, 0, 32'h024); // 18 miss not-taken: no alloc
    add(32'h020, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h024); // 19 still miss
    add(32'h020, 0, 32'h020, 1, 32'h500, 0, 0,  0, 0, 32'h024); // 20 upd_valid=0 ignored
    add(32'h020, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h024); // 21 still miss
    add(32'hFFFFFFFC, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000); // 22 pc+4 wraps
    add(32'h142, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h200); // 23 pc[1:0] ignored
    add(32'h140, 1, 32'h140, 1, 32'h200, 0, 0,  1, 1, 32'h200); // 24 10 -> 11
    add(32'h140, 1, 32'h140, 1, 32'h200, 0, 0,  1, 1, 32'h200); // 25 saturate at 11
    add(32'h140, 1, 32'h140, 0, 32'h000, 0, 0,  1, 1, 32'h200); // 26 11 -> 10
    add(32'h140, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h200); // 27 still taken

    // Reset state
    #1 rstn = 1'b0;
    pc_f = 32'h100;
    #2;
    check_pred("reset", 1'b0, 1'b0, 32'h104);
    check("reset stat_upd",  stat_upd,  32'd0);
    check("reset stat_miss", stat_miss, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 check_pred("post-reset", 1'b0, 1'b0, 32'h104);

    // Table vectors
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      pc_f = vt[i].pc;
      drive_upd(vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utgt, vt[i].uj, vt[i].um);
      #1 check_pred($sformatf("v%0d", i), vt[i].eh, vt[i].et, vt[i].etgt);
    end

    // Async reset mid-sequence: entry 0x10 is live, then rstn drops between edges
    @(negedge clk);
    drive_upd(1, 32'h010, 1, 32'h300, 1, 0);
    @(negedge clk);
    drive_upd(1, 32'h010, 0, 32'h000, 0, 0);
    @(negedge clk);
    drive_upd(0, 32'h000, 0, 32'h000, 0, 0);
    pc_f = 32'h010;
    #1 check_pred("pre-rst", 1'b1, 1'b1, 32'h300);
    #1 rstn = 1'b0;
    #1 check_pred("async-rst", 1'b0, 1'b0, 32'h014);
    check("async-rst stat_upd",  stat_upd,  32'd0);
    check("async-rst stat_miss", stat_miss, 32'd0);
    // An update presented during reset must be dropped.
    drive_upd(1, 32'h010, 1, 32'h300, 1, 1);
    @(negedge clk);
    drive_upd(0, 32'h000, 0, 32'h000, 0, 0);
    rstn = 1'b1;
    #1 check_pred("rst-drop", 1'b0, 1'b0, 32'h014);
    check("rst-drop stat_upd", stat_upd, 32'd0);

    // Statistics: 5 updates, 2 flagged mispredicted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_upd(1, 32'h200 + 32'(i * 4), 1, 32'h800, 0, (i == 1 || i == 3));
    end
    @(negedge clk);
    drive_upd(0, 32'h000, 0, 32'h000, 0, 0);
`ifdef BP_STATS_EN
    exp_upd  = 32'd5;
    exp_miss = 32'd2;
`else
    exp_upd  = 32'd0;
    exp_miss = 32'd0;
`endif
    #1 check("stat_upd",  stat_upd,  exp_upd);
    check("stat_miss", stat_miss, exp_miss);
    pc_f = 32'h208;
    #1 check_pred("stats-entry", 1'b1, 1'b1, 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, BTB/BHT entry count, power of two, 4..256.
REQ-003 SHALL have parameter CNT_W, default 2, saturating-counter width, 1..4.
REQ-004 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc_f  in  XLEN  fetch-stage PC to predict.
REQ-007 SHALL have port pred_hit  out  1  valid entry with matching tag for pc_f.
REQ-008 SHALL have port pred_taken  out  1  predicted taken.
REQ-009 SHALL have port pred_target  out  XLEN  predicted next PC.
REQ-010 SHALL have port upd_valid  in  1  resolved control-flow instruction this cycle.
REQ-011 SHALL have port upd_pc  in  XLEN  PC of the resolved instruction.
REQ-012 SHALL have port upd_taken  in  1  actual outcome.
REQ-013 SHALL have port upd_target  in  XLEN  actual taken target.
REQ-014 SHALL have port upd_is_jmp  in  1  resolved instruction is jal/jalr, not a conditional branch.
REQ-015 SHALL have port upd_mispred  in  1  pipeline flushed on this update.
REQ-016 SHALL have port stat_upd  out  32  count of accepted updates.
REQ-017 SHALL have port stat_miss  out  32  count of mispredictions.

Function
REQ-018 SHALL compute index = pc[IW+1:2] and tag = pc[XLEN-1:IW+2], with IW = log2(ENTRIES); pc[1:0] ignored.
REQ-019 SHALL produce lookup outputs combinationally from pc_f and current table state, with zero-cycle latency.
REQ-020 SHALL drive pred_hit = valid[idx] and tag match.
REQ-021 SHALL drive pred_taken = pred_hit and counter MSB.
REQ-022 SHALL drive pred_target = stored target when pred_taken, else pc_f + 4 (mod 2^XLEN).
REQ-023 SHALL, on upd_valid with miss and upd_taken, allocate the entry at rising edge: valid=1, tag, target=upd_target, counter=weakly-taken (MSB=1, rest 0); any aliased entry is overwritten.
REQ-024 SHALL, on upd_valid with miss and not upd_taken, leave the table unchanged.
REQ-025 SHALL, on upd_valid with hit, increment (taken) or decrement (not taken) the counter with saturation at all-ones/zero, and write target only when taken.
REQ-026 SHALL force the counter to all-ones when upd_is_jmp and upd_taken.
REQ-027 SHALL, when a lookup and an update hit the same index in one cycle, show the pre-update state on lookup outputs, with the new state visible next cycle; no bypass.
REQ-028 SHALL ignore update inputs when upd_valid=0.

Reset
REQ-029 SHALL, while rstn=0, asynchronously clear all valid bits, set all counters to weakly-not-taken (MSB=0, rest 1), and zero the statistic counters.
REQ-030 SHALL, during and immediately after reset, drive pred_hit=0, pred_taken=0, pred_target=pc_f+4; an update in the reset cycle is dropped.

Configuration
REQ-031 SHALL, with BP_STATS_EN defined, increment stat_upd on each upd_valid and stat_miss on each upd_valid and upd_mispred, each saturating at 0xFFFFFFFF.
REQ-032 SHALL, without BP_STATS_EN, tie stat_upd and stat_miss to 0 and instantiate no statistic registers.

Structure
REQ-033 SHALL place counter-encoding constants, default parameter values and the index/tag width functions in shared package bp_pkg.
REQ-034 SHALL implement saturating-counter next-state logic in one sub-module, sat_counter, parametrised by CNT_W.

Verification (XLEN=32, ENTRIES=16, CNT_W=2)
REQ-035 SHALL cover: reset, then pc_f=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-036 SHALL cover: update 0x100 taken, target 0x80, then next cycle pc_f=0x100 -> hit=1, taken=1, target=0x80; one not-taken update -> taken=0, target=0x104.
REQ-037 SHALL cover: 0x100 allocated, pc_f=0x140 (same index, other tag) -> hit=0; update 0x140 taken, target 0x200 -> 0x140 hits and 0x100 misses.
REQ-038 SHALL cover: update 0x100 taken while pc_f=0x100 in the same cycle -> hit=0 that cycle, hit=1 the next.
REQ-039 SHALL cover: jal update 0x10 taken, target 0x300, followed by 3 not-taken updates -> counter 11->00, taken=0; rstn pulsed mid-sequence -> hit=0 immediately, asynchronously.
REQ-040 SHALL cover: with BP_STATS_EN, 5 updates with 2 mispredicts -> stat_upd=5, stat_miss=2; without the macro, both read 0.
